// File: rtl/alu64bit.sv
// alu64bit: 64-bit four-function ALU (NOR, XOR, add, subtract form) built
// from a ripple chain of one-bit slices, with the result and carry-out
// captured in an asynchronously reset output register (1-cycle latency).

// One-bit ALU slice: computes this bit of the result and the carry onward.
module alu64bit_slice (
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic [1:0] op,
   output logic       s,
   output logic       co
);

   logic b_eff;
   logic arith;

   // Subtract form inverts b; the carry chain is only active for arithmetic.
   always_comb begin
      arith = op[1];
      b_eff = (op == 2'b11) ? ~b : b;
      s     = 1'b0;
      co    = 1'b0;
      case (op)
         2'b00: s = ~(a | b);
         2'b01: s = a ^ b;
         default: begin
            s  = a ^ b_eff ^ c;
            co = arith & ((a & b_eff) | (a & c) | (b_eff & c));
         end
      endcase
   end

endmodule

// Top level: 64 slices in a ripple chain, then the output register.
module alu64bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        cin,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic [1:0]  op,
   output logic [63:0] s,
   output logic        cout
);

   // carry[i] feeds slice i; carry[64] is the carry out of slice 63.
   logic [64:0] carry;
   logic [63:0] s_next;
   logic        cout_next;
   logic [63:0] s_reg;
   logic        cout_reg;

   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < 64; gi = gi + 1) begin : g_slice
         alu64bit_slice u_slice (
            .a  (a[gi]),
            .b  (b[gi]),
            .c  (carry[gi]),
            .op (op),
            .s  (s_next[gi]),
            .co (carry[gi+1])
         );
      end
   endgenerate

   // Carry-out is meaningful only for the arithmetic ops; logic ops force 0.
   always_comb begin
      cout_next = op[1] ? carry[64] : 1'b0;
   end

   // Output register: reset clears immediately, otherwise load every edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_reg    <= 64'h0;
         cout_reg <= 1'b0;
      end else begin
         s_reg    <= s_next;
         cout_reg <= cout_next;
      end
   end

   assign s    = s_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_alu64bit.sv
// tb_alu64bit: directed-vector self-checking bench for alu64bit.
`timescale 1ns/1ps
module tb_alu64bit;

   logic        clk;
   logic        rst;
   logic        cin;
   logic [63:0] a;
   logic [63:0] b;
   logic [1:0]  op;
   logic [63:0] s;
   logic        cout;

   int checks;
   int errors;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   alu64bit dut (
      .clk  (clk),
      .rst  (rst),
      .cin  (cin),
      .a    (a),
      .b    (b),
      .op   (op),
      .s    (s),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] s_exp, input logic c_exp);
      checks++;
      assert (s === s_exp) else begin
         errors++;
         $error("FAIL %s s observed=%h expected=%h", tag, s, s_exp);
      end
      checks++;
      assert (cout === c_exp) else begin
         errors++;
         $error("FAIL %s cout observed=%b expected=%b", tag, cout, c_exp);
      end
      $display("%0t %s a=%h b=%h op=%b cin=%b -> s=%h cout=%b", $time, tag, a, b, op, cin, s, cout);
   endtask

   task automatic drive(input logic [63:0] av, input logic [63:0] bv, input logic [1:0] opv, input logic cv);
      a   = av;
      b   = bv;
      op  = opv;
      cin = cv;
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Asynchronous reset with arbitrary inputs, before any clock edge.
      rst = 1'b1;
      drive(ONES, ONES, 2'b10, 1'b1);
      #2;
      check("reset_async", 64'h0, 1'b0);

      // Release reset; first edge loads the current inputs.
      drive(64'd5, 64'd3, 2'b11, 1'b1);
      rst = 1'b0;
      edge_wait();
      check("reset_release_sub_5_3", 64'd2, 1'b1);

      drive(ONES, 64'h0, 2'b10, 1'b0);
      edge_wait();
      check("add_ones_cin0", ONES, 1'b0);

      drive(ONES, 64'h0, 2'b10, 1'b1);
      edge_wait();
      check("add_ones_cin1_wrap", 64'h0, 1'b1);

      drive(64'd3, 64'd5, 2'b11, 1'b1);
      edge_wait();
      check("sub_3_5", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

      drive(64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 2'b01, 1'b1);
      edge_wait();
      check("xor_cin1", 64'hFF00_FF00_FF00_FF00, 1'b0);

      drive(64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 2'b00, 1'b1);
      edge_wait();
      check("nor_cin1", 64'h000F_000F_000F_000F, 1'b0);

      drive(ONES, 64'd1, 2'b10, 1'b0);
      edge_wait();
      check("full_ripple", 64'h0, 1'b1);

      drive(ONES, ONES, 2'b10, 1'b1);
      edge_wait();
      check("ones_plus_ones_cin1", ONES, 1'b1);

      drive(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'b11, 1'b1);
      edge_wait();
      check("a_minus_a", 64'h0, 1'b1);

      drive(64'h0, 64'd1, 2'b11, 1'b1);
      edge_wait();
      check("zero_minus_one", ONES, 1'b0);

      drive(64'd10, 64'd3, 2'b11, 1'b0);
      edge_wait();
      check("sub_cin0_10_3", 64'd6, 1'b1);

      // Outputs hold across edges with stable inputs and ignore input changes
      // until the next edge.
      edge_wait();
      check("hold_stable", 64'd6, 1'b1);
      drive(64'd100, 64'd1, 2'b10, 1'b0);
      #2;
      check("hold_no_edge", 64'd6, 1'b1);

      // Pipeline: a new vector every cycle, reset between edges 2 and 3.
      edge_wait();
      check("pipe_r0", 64'd101, 1'b0);
      drive(64'd1, 64'd2, 2'b11, 1'b1);
      edge_wait();
      check("pipe_r1", ONES, 1'b0);
      drive(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 2'b01, 1'b0);
      rst = 1'b1;
      #1;
      check("pipe_mid_reset", 64'h0, 1'b0);
      #1;
      rst = 1'b0;
      #1;
      check("pipe_after_release_no_edge", 64'h0, 1'b0);
      edge_wait();
      check("pipe_r2", ONES, 1'b0);
      drive(64'hFFFF_0000_FFFF_0000, 64'h0, 2'b00, 1'b1);
      edge_wait();
      check("pipe_r3", 64'h0000_FFFF_0000_FFFF, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu64bit.md
ALU64BIT -- requirements
Module: alu64bit

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cin  input  1  carry-in for arithmetic operations.
REQ-005 a  input  64  first operand; bit 0 is the LSB.
REQ-006 b  input  64  second operand; bit 0 is the LSB.
REQ-007 op  input  2  operation select.
REQ-008 s  output  64  registered result.
REQ-009 cout  output  1  registered carry-out.

Function
REQ-010 The op encoding SHALL be:
- 2'b00: s = ~(a | b), bitwise NOR.
- 2'b01: s = a ^ b, bitwise XOR.
- 2'b10: {cout,s} = a + b + cin.
- 2'b11: {cout,s} = a + ~b + cin, subtract form.
REQ-011 For op 2'b11 with cin=1, s SHALL equal a - b mod 2^64, and cout SHALL be 1 exactly when a >= b unsigned (no borrow).
REQ-012 For op 2'b11 with cin=0, s SHALL equal a - b - 1 mod 2^64.
REQ-013 For logic ops (2'b00, 2'b01), cout SHALL be 0 and cin SHALL be ignored.
REQ-014 Arithmetic SHALL be unsigned modulo 2^64, with cout the 65th bit of the 65-bit sum; signed overflow is not reported.
REQ-015 The datapath SHALL be a ripple chain of 64 one-bit ALU slices.
- Each slice takes a[i], b[i], a carry-in and op, and produces s[i] and a carry-out.
- Slice 0 carry-in = cin; slice i carry-in = slice i-1 carry-out.
- cout is taken from slice 63 carry-out, gated to 0 for logic ops.
REQ-016 Inputs SHALL be sampled combinationally and the result registered: s and cout update on the rising clk edge following the inputs, i.e. 1-cycle latency.
REQ-017 A new operation SHALL be accepted every cycle (throughput 1/cycle), with no handshake; inputs changing every cycle produce a matching result stream delayed by exactly one cycle.
REQ-018 Outputs SHALL hold their value while inputs are stable; only clk edges change s and cout outside reset.
REQ-019 Boundary behaviour SHALL be:
- all-ones + 0 + cin=1 wraps to s=0, cout=1.
- all-ones + all-ones + cin=1 gives s=all-ones, cout=1.
- a - a with cin=1 gives s=0, cout=1.
- 0 - 1 with cin=1 gives s=all-ones, cout=0.

Reset
REQ-020 While rst=1, s SHALL be 64'h0 and cout SHALL be 0, asynchronously, regardless of clk.
REQ-021 Assertion of rst mid-operation SHALL immediately discard the pending result.
REQ-022 The first rising clk edge with rst=0 SHALL load the result of the current inputs.

Verification
REQ-023 Reset check: rst=1 with any inputs -> s=0, cout=0 without any clk edge; release rst, one edge -> result appears.
REQ-024 Carry-in check, one edge per case:
- a=64'hFFFF_FFFF_FFFF_FFFF, b=0, op=2'b10, cin=0 -> s=64'hFFFF_FFFF_FFFF_FFFF, cout=0.
- Same with cin=1 -> s=0, cout=1.
REQ-025 Subtract check, op=2'b11, cin=1:
- a=5, b=3 -> s=2, cout=1.
- a=3, b=5 -> s=64'hFFFF_FFFF_FFFF_FFFE, cout=0.
REQ-026 Logic check, cin=1 (cout must still be 0):
- a=64'hF0F0_F0F0_F0F0_F0F0, b=64'h0FF0_0FF0_0FF0_0FF0, op=2'b01 -> s=64'hFF00_FF00_FF00_FF00, cout=0.
- Same a and b, op=2'b00 -> s=64'h000F_000F_000F_000F, cout=0.
REQ-027 Full ripple check: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, op=2'b10, cin=0 -> s=0, cout=1, confirming carry propagation through all 64 slices.
REQ-028 Pipeline check: change inputs on each of 4 consecutive cycles -> each result appears exactly one edge later, in order; assert rst between edges 2 and 3 -> outputs 0 at once, and the stream resumes after the first edge with rst=0.
